jtkiwi_sub_shr: RTL and testbench
=================================

Name: jtkiwi_sub_shr

Overview:
- Sub (sound) CPU side of the main/sub shared-RAM link: the requester end of the main CPU's shared-RAM arbitration.
- Decodes sub-CPU memory cycles that fall inside the 8 kB shared window and raises shr_cs toward the main-side arbiter.
- Stalls the sub CPU with wait_n until the arbiter grants the RAM, then performs exactly one RAM access.
- Returns read data to the sub CPU and releases the RAM when the CPU bus cycle ends.

Parameters:
- SHR_BASE, 3'b110: value of sub A[15:13] that selects the shared window (C000-DFFF).
- RD_LAT, 1: clocks from grant to valid shr_dout (dual-port RAM read is registered).
- TOUT, 255: clocks in REQ before the sticky timeout flag sets; maximum 255.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cen  in  1  sub CPU clock enable; used only to qualify bus sampling
- snd_rstn  in  1  sub CPU reset from main-CPU bank register; low = abort
- A  in  16  sub CPU address
- cpu_dout  in  8  sub CPU write data
- mreq_n, rfsh_n, rd_n, wr_n  in  1 each  sub CPU bus strobes
- wait_n  out  1  sub CPU wait request
- cpu_din  out  8  read data to sub CPU, registered
- shr_addr  out  13  shared RAM address
- shr_din  out  8  shared RAM write data
- sub_rnw  out  1  1 = read, 0 = write strobe
- shr_cs  out  1  request/hold of the shared RAM
- shr_ok  in  1  grant from arbiter: the main-side sub-enable flag
- mshramen  in  1  main CPU currently owns the RAM
- shr_dout  in  8  shared RAM read port
- tout_flag  out  1  sticky: a request waited longer than TOUT

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE, wait_n=1, shr_cs=0, sub_rnw=1, shr_addr=0, shr_din=0, cpu_din=0, tout_flag=0, counters=0.
- hit = cen & ~mreq_n & rfsh_n & (~rd_n | ~wr_n) & A[15:13]==SHR_BASE.
- IDLE:
  - On hit: latch A[12:0] into shr_addr, cpu_dout into shr_din, and rnw_l=wr_n.
  - Assert shr_cs=1 and wait_n=0 on the same edge.
  - Go to REQ.
  - A non-hit cycle leaves all outputs unchanged.
- REQ:
  - Hold shr_cs=1, wait_n=0, sub_rnw=1.
  - tcnt increments each clock and saturates at TOUT; when tcnt==TOUT, set tout_flag. Keep waiting; never self-abort.
  - When shr_ok=1 and mshramen=0: go to ACC and clear lcnt.
- ACC:
  - Write: sub_rnw=0 for exactly the first ACC clock, then 1.
  - Read: lcnt counts to RD_LAT; on lcnt==RD_LAT, capture shr_dout into cpu_din.
  - Go to DONE after RD_LAT+1 clocks, both reads and writes.
  - If shr_ok drops mid-ACC (arbiter protocol violation), return to REQ and restart the access.
- DONE:
  - wait_n=1; shr_cs stays 1 until mreq_n=1, then shr_cs=0 and go to IDLE.
  - A single CPU cycle therefore produces exactly one RAM write.
- Throughput: a back-to-back hit is taken only from IDLE. shr_cs is low for at least one clock between accesses, so the main side gets an arbitration slot.
- snd_rstn=0 (any state, synchronous priority over everything except rst_n):
  - Go to IDLE; shr_cs=0, wait_n=1, sub_rnw=1.
  - cpu_din and tout_flag keep their values.
  - No partial write: a write already in ACC is dropped only if snd_rstn falls before the ACC edge.
- Reset mid-operation (rst_n low): all outputs return to reset values immediately.
- cpu_din is updated only by window reads; reads outside the window do not touch it.

Test Plan:
- Read when free: RAM[0x0123]=0x5A, shr_ok rises 2 clk after shr_cs, sub reads C123 -> shr_addr=0x0123, wait_n low about 2+RD_LAT+1 clk, cpu_din=0x5A, shr_cs falls the clock after mreq_n=1.
- Write when free: sub writes 0xA7 to DFFF -> shr_addr=0x1FFF, shr_din=0xA7, sub_rnw=0 for exactly 1 clk, RAM[0x1FFF]=0xA7, wait_n released.
- Contention: mshramen=1 for 20 clk while the sub requests -> wait_n stays 0 and sub_rnw stays 1 throughout; the access completes after mshramen falls and shr_ok=1; data is correct.
- Window miss: accesses to 0x8000 and 0xE000, plus refresh cycles with A=0xC000 -> shr_cs stays 0, wait_n stays 1.
- Abort: snd_rstn pulled low during REQ -> next clk shr_cs=0, wait_n=1, RAM unchanged; after snd_rstn=1 a new read succeeds.
- Timeout: shr_ok held 0 for 300 clk -> tout_flag=1 at clock 255 and stays set; wait_n=0 until the grant; rst_n low clears the flag.

Source files
------------

// File: rtl/jtkiwi_sub_shr.sv
// ----------------------------------------------------------------------------
// jtkiwi_sub_shr : sub-CPU requester end of the main/sub shared-RAM link.
// Revision 1.0 - initial release
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module jtkiwi_sub_shr #(
  parameter logic [2:0] SHR_BASE = 3'b110,
  parameter int         RD_LAT   = 1,
  parameter int         TOUT     = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cen,
  input  logic        snd_rstn,
  input  logic [15:0] A,
  input  logic [7:0]  cpu_dout,
  input  logic        mreq_n,
  input  logic        rfsh_n,
  input  logic        rd_n,
  input  logic        wr_n,
  output logic        wait_n,
  output logic [7:0]  cpu_din,
  output logic [12:0] shr_addr,
  output logic [7:0]  shr_din,
  output logic        sub_rnw,
  output logic        shr_cs,
  input  logic        shr_ok,
  input  logic        mshramen,
  input  logic [7:0]  shr_dout,
  output logic        tout_flag
);

  localparam logic [7:0] c_tout   = 8'(TOUT);
  localparam logic [7:0] c_rd_lat = 8'(RD_LAT);

  typedef enum logic [1:0] {IDLE, REQ, ACC, DONE} state_t;

  state_t      r_state, w_state_nx;
  logic [7:0]  r_tcnt, w_tcnt_nx;
  logic [7:0]  r_lcnt, w_lcnt_nx;
  logic        r_rnw_l, w_rnw_l_nx;
  logic        w_wait_n_nx, w_shr_cs_nx, w_sub_rnw_nx, w_tout_nx;
  logic [12:0] w_shr_addr_nx;
  logic [7:0]  w_shr_din_nx, w_cpu_din_nx;
  logic        w_hit;

  assign w_hit = cen & ~mreq_n & rfsh_n & (~rd_n | ~wr_n) & (A[15:13] == SHR_BASE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_tcnt    <= '0;
      r_lcnt    <= '0;
      r_rnw_l   <= 1'b1;
      wait_n    <= 1'b1;
      shr_cs    <= 1'b0;
      sub_rnw   <= 1'b1;
      shr_addr  <= '0;
      shr_din   <= '0;
      cpu_din   <= '0;
      tout_flag <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_tcnt    <= w_tcnt_nx;
      r_lcnt    <= w_lcnt_nx;
      r_rnw_l   <= w_rnw_l_nx;
      wait_n    <= w_wait_n_nx;
      shr_cs    <= w_shr_cs_nx;
      sub_rnw   <= w_sub_rnw_nx;
      shr_addr  <= w_shr_addr_nx;
      shr_din   <= w_shr_din_nx;
      cpu_din   <= w_cpu_din_nx;
      tout_flag <= w_tout_nx;
    end
  end

  always_comb begin
    w_state_nx    = r_state;
    w_tcnt_nx     = r_tcnt;
    w_lcnt_nx     = r_lcnt;
    w_rnw_l_nx    = r_rnw_l;
    w_wait_n_nx   = wait_n;
    w_shr_cs_nx   = shr_cs;
    w_sub_rnw_nx  = sub_rnw;
    w_shr_addr_nx = shr_addr;
    w_shr_din_nx  = shr_din;
    w_cpu_din_nx  = cpu_din;
    w_tout_nx     = tout_flag;
    if (!snd_rstn) begin
      // Sub CPU held in reset: drop the request but keep read data and flag
      w_state_nx   = IDLE;
      w_shr_cs_nx  = 1'b0;
      w_wait_n_nx  = 1'b1;
      w_sub_rnw_nx = 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_hit) begin
            w_shr_addr_nx = A[12:0];
            w_shr_din_nx  = cpu_dout;
            w_rnw_l_nx    = wr_n;
            w_shr_cs_nx   = 1'b1;
            w_wait_n_nx   = 1'b0;
            w_sub_rnw_nx  = 1'b1;
            w_tcnt_nx     = '0;
            w_state_nx    = REQ;
          end
        end
        REQ: begin
          w_shr_cs_nx  = 1'b1;
          w_wait_n_nx  = 1'b0;
          w_sub_rnw_nx = 1'b1;
          if (r_tcnt != c_tout) w_tcnt_nx = r_tcnt + 8'd1;
          if (w_tcnt_nx == c_tout) w_tout_nx = 1'b1;
          if (shr_ok && !mshramen) begin
            // Write strobe is issued for the first ACC clock only
            w_sub_rnw_nx = r_rnw_l;
            w_lcnt_nx    = '0;
            w_state_nx   = ACC;
          end
        end
        ACC: begin
          w_sub_rnw_nx = 1'b1;
          if (!shr_ok) begin
            w_state_nx = REQ;
          end else if (r_lcnt == c_rd_lat) begin
            if (r_rnw_l) w_cpu_din_nx = shr_dout;
            w_wait_n_nx = 1'b1;
            w_state_nx  = DONE;
          end else begin
            w_lcnt_nx = r_lcnt + 8'd1;
          end
        end
        DONE: begin
          // Hold the RAM until the CPU bus cycle ends
          w_wait_n_nx = 1'b1;
          if (mreq_n) begin
            w_shr_cs_nx = 1'b0;
            w_state_nx  = IDLE;
          end
        end
        default: w_state_nx = IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_jtkiwi_sub_shr.sv
// Scoreboard bench for jtkiwi_sub_shr: sub CPU bus driver, arbiter and dual-port RAM models.
`timescale 1ns/1ps

module tb_jtkiwi_sub_shr;

  logic        clk = 1'b0, rst_n = 1'b0, cen = 1'b1, snd_rstn = 1'b1;
  logic [15:0] A = '0;
  logic [7:0]  cpu_dout = '0;
  logic        mreq_n = 1'b1, rfsh_n = 1'b1, rd_n = 1'b1, wr_n = 1'b1;
  logic        wait_n, sub_rnw, shr_cs, tout_flag;
  logic [7:0]  cpu_din, shr_din;
  logic [12:0] shr_addr;
  logic        shr_ok = 1'b0, mshramen = 1'b0;
  logic [7:0]  shr_dout = '0;
  logic [7:0]  mem [0:8191];

  typedef struct {bit rd; logic [12:0] addr; logic [7:0] data;} exp_t;
  exp_t sb[$];

  int vectors = 0, errors = 0;
  int gdly = 2, ok_cnt = 0, rnw_lo = 0, lo, r0;
  bit arb_block = 1'b0;
  logic prev_w = 1'b1;

  jtkiwi_sub_shr dut (
    .clk(clk), .rst_n(rst_n), .cen(cen), .snd_rstn(snd_rstn), .A(A),
    .cpu_dout(cpu_dout), .mreq_n(mreq_n), .rfsh_n(rfsh_n), .rd_n(rd_n), .wr_n(wr_n),
    .wait_n(wait_n), .cpu_din(cpu_din), .shr_addr(shr_addr), .shr_din(shr_din),
    .sub_rnw(sub_rnw), .shr_cs(shr_cs), .shr_ok(shr_ok), .mshramen(mshramen),
    .shr_dout(shr_dout), .tout_flag(tout_flag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Dual-port RAM with registered read; a few cells preloaded during reset
  always @(posedge clk) begin
    if (!rst_n) begin
      mem[13'h0123] <= 8'h5A;
      mem[13'h0456] <= 8'h3C;
      mem[13'h0010] <= 8'h11;
    end else if (!sub_rnw) begin
      mem[shr_addr] <= shr_din;
    end
    shr_dout <= mem[shr_addr];
  end

  // Arbiter: grants gdly clocks after shr_cs, withdraws when shr_cs drops
  always @(negedge clk) begin
    if (!shr_cs || arb_block) begin
      ok_cnt = 0;
      shr_ok = 1'b0;
    end else begin
      ok_cnt++;
      if (ok_cnt >= gdly) shr_ok = 1'b1;
    end
    if (!sub_rnw) rnw_lo++;
  end

  // Monitor: every wait_n release of a live access completes one expected transaction
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n && snd_rstn && wait_n && !prev_w) begin
      if (sb.size() == 0) begin
        vectors++;
        errors++;
        $display("FAIL release: no pending access, queue size %0d required >0", sb.size());
      end else begin
        e = sb.pop_front();
        chk("addr", 32'(shr_addr), 32'(e.addr));
        if (e.rd) chk("rdata", 32'(cpu_din), 32'(e.data));
        else begin
          chk("wdata", 32'(shr_din), 32'(e.data));
          chk("ram", 32'(mem[e.addr]), 32'(e.data));
        end
      end
    end
    prev_w = wait_n;
  end

  task automatic bus(input logic [15:0] a, input bit rd, input logic [7:0] d, input bit hit,
                     output int nlo);
    @(negedge clk);
    A = a; cpu_dout = d; mreq_n = 1'b0; rd_n = !rd; wr_n = rd;
    if (hit) sb.push_back(exp_t'{rd, a[12:0], d});
    nlo = 0;
    for (int n = 0; n < 2000; n++) begin
      @(negedge clk);
      if (wait_n) break;
      nlo++;
    end
    if (!wait_n) begin
      vectors++;
      errors++;
      $display("FAIL wait_timeout: wait_n still 0 after %0d clk, required release", nlo);
    end
    mreq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
    @(negedge clk);
    if (hit) chk("cs_release", 32'(shr_cs), 0);
  endtask

  task automatic miss(input string name, input logic [15:0] a, input bit rdn, input bit wrn,
                      input bit rfn);
    bit ok = 1'b1;
    @(negedge clk);
    A = a; cpu_dout = 8'hEE; mreq_n = 1'b0; rd_n = rdn; wr_n = wrn; rfsh_n = rfn;
    repeat (3) begin
      @(negedge clk);
      if (shr_cs || !wait_n) ok = 1'b0;
    end
    chk(name, 32'(ok), 1);
    mreq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1; rfsh_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_wait_n", 32'(wait_n), 1);
    chk("rst_shr_cs", 32'(shr_cs), 0);
    chk("rst_sub_rnw", 32'(sub_rnw), 1);
    chk("rst_shr_addr", 32'(shr_addr), 0);
    chk("rst_shr_din", 32'(shr_din), 0);
    chk("rst_cpu_din", 32'(cpu_din), 0);
    chk("rst_tout", 32'(tout_flag), 0);
    rst_n = 1'b1;

    // Read when free
    r0 = rnw_lo;
    bus(16'hC123, 1'b1, 8'h5A, 1'b1, lo);
    chk("rd_wait_clks", 32'(lo), 4);
    chk("rd_no_strobe", 32'(rnw_lo - r0), 0);

    // Write when free
    r0 = rnw_lo;
    bus(16'hDFFF, 1'b0, 8'hA7, 1'b1, lo);
    chk("wr_strobe_clks", 32'(rnw_lo - r0), 1);
    chk("wr_wait_clks", 32'(lo), 4);

    // Contention with the main CPU
    mshramen = 1'b1;
    r0 = rnw_lo;
    fork
      bus(16'hC456, 1'b1, 8'h3C, 1'b1, lo);
      begin repeat (20) @(negedge clk); mshramen = 1'b0; end
    join
    chk("cont_no_strobe", 32'(rnw_lo - r0), 0);
    chk("cont_wait_long", 32'(lo > 20), 1);

    // Window misses and refresh
    miss("miss_8000", 16'h8000, 1'b0, 1'b1, 1'b1);
    chk("miss_keeps_din", 32'(cpu_din), 32'h3C);
    miss("miss_E000", 16'hE000, 1'b1, 1'b0, 1'b1);
    miss("miss_rfsh", 16'hC000, 1'b0, 1'b1, 1'b0);

    // Abort during REQ
    arb_block = 1'b1;
    @(negedge clk);
    A = 16'hC010; cpu_dout = 8'h99; mreq_n = 1'b0; wr_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_req_cs", 32'(shr_cs), 1);
    chk("abort_req_wait", 32'(wait_n), 0);
    chk("abort_req_addr", 32'(shr_addr), 32'h010);
    snd_rstn = 1'b0;
    @(negedge clk);
    chk("abort_cs", 32'(shr_cs), 0);
    chk("abort_wait", 32'(wait_n), 1);
    chk("abort_rnw", 32'(sub_rnw), 1);
    mreq_n = 1'b1; wr_n = 1'b1;
    @(negedge clk);
    snd_rstn = 1'b1;
    arb_block = 1'b0;
    @(negedge clk);
    chk("abort_ram", 32'(mem[13'h0010]), 32'h11);
    bus(16'hC010, 1'b1, 8'h11, 1'b1, lo);

    // Timeout: grant withheld for 300 clk
    arb_block = 1'b1;
    fork
      bus(16'hC123, 1'b1, 8'h5A, 1'b1, lo);
      begin
        for (int n = 0; n < 20 && !shr_cs; n++) @(negedge clk);
        repeat (254) @(negedge clk);
        chk("tout_early", 32'(tout_flag), 0);
        @(negedge clk);
        chk("tout_set", 32'(tout_flag), 1);
        repeat (44) @(negedge clk);
        chk("tout_still_wait", 32'(wait_n), 0);
        arb_block = 1'b0;
      end
    join
    chk("tout_sticky", 32'(tout_flag), 1);
    chk("sb_drained", 32'(sb.size()), 0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_tout_clr", 32'(tout_flag), 0);
    chk("rst_cpu_din_clr", 32'(cpu_din), 0);
    chk("rst_addr_clr", 32'(shr_addr), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
